shift_scheduler: RTL and testbench
==================================

# shift_scheduler

Multi-cycle shift-left engine shared by two requesters. A round-robin arbiter grants one request at a time, and the block performs a logical left shift of up to N bit positions in steps of at most STEP bits per cycle. The result is returned on a valid/ready response channel tagged with the requester id. It sits between issue logic and the shared shifter resource in the datapath, sequencing the shifter.

## Interface
Parameters:
- N, default 8: data width.
- A, default $clog2(N)+1: shift-amount width, able to represent N.
- STEP, default 2: maximum bit positions shifted per cycle, 1 ≤ STEP ≤ N.

Ports:
- clk  in  1  single clock; everything is registered on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_d  in  N  requester 0 operand.
- req0_amt  in  A  requester 0 shift amount.
- req1_valid, req1_ready, req1_d, req1_amt: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_out  out  N  shifted result.
- rsp_id  out  1  requester that owns rsp_out.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **Registers:**
  - acc[N]: accumulator.
  - rem: remaining shift count, range 0..N.
  - id[1]: owner of the current job.
  - last[1]: requester served most recently.
- **IDLE:**
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to !last. After reset last=1, so req0 wins first.
  - reqX_ready = (state==IDLE) && grantX && rst. It is combinational and never high for both requesters.
  - Accept occurs when reqX_valid && reqX_ready. On accept: acc←reqX_d, rem←min(reqX_amt, N), id←X.
  - Next state is SHIFT if rem≠0, otherwise DONE.
- **SHIFT:**
  - Each cycle: s=min(rem, STEP), acc←acc<<s (zero fill), rem←rem−s.
  - When the new rem is 0, go to DONE.
- **DONE:**
  - rsp_valid=1; rsp_out=acc; rsp_id=id.
  - When rsp_ready is high: last←id, go to IDLE.
- **Amount rules:**
  - amt ≥ N produces 0.
  - amt = 0 returns d unchanged.
  - Overflowed bits are discarded.
- **Input capture:** requester inputs are sampled only on the accept edge. Changes after accept have no effect.

## Timing
- **Reset** (rst low at an edge):
  - state=IDLE, acc=0, rem=0, id=0, last=1.
  - rsp_valid=0, rsp_out=0, rsp_id=0, busy=0.
  - req0_ready=req1_ready=0 for as long as rst is low.
- **Reset mid-operation** (SHIFT or DONE): the job is aborted with no response, and the block is in IDLE on the next cycle.
- **Latency:** with r=min(amt,N) and k=ceil(r/STEP), rsp_valid rises k cycles after the accepting edge. For r=0 it rises on the accepting edge itself.
- **Response hold:** rsp_valid, rsp_out and rsp_id are stable while rsp_valid && !rsp_ready. rsp_valid is deasserted only after the handshake edge.
- **Throughput:**
  - One job in flight.
  - After the response handshake, the block spends one IDLE cycle. The next accept happens on the following edge at the earliest.
  - The minimum period is k+2 cycles per job.
- **Ready in non-IDLE states:** both readys are 0 in SHIFT and DONE, regardless of valid.
- **Simultaneous valid:** round-robin alternation, so neither requester waits more than one job.

## Test plan
- **Reset:** rst=0 for 2 cycles with req0_valid=1, req1_valid=1 -> req0_ready=req1_ready=0, rsp_valid=0, rsp_out=8'h00, busy=0. After release, req0 is granted first.
- **Basic shift:** req0 d=8'h01, amt=3, STEP=2 -> accepted; rsp_valid rises 2 cycles later with rsp_out=8'h08, rsp_id=0. busy is high from accept until the response handshake.
- **Arbitration:** both valid; req0 d=8'h81 amt=1, req1 d=8'h0F amt=4 -> first response 8'h02 id=0, second response 8'hF0 id=1. Both re-presented -> req0 served next (alternation).
- **Amount boundaries:**
  - amt=0, d=8'hA5 -> rsp_out=8'hA5 with rsp_valid on the accept edge.
  - amt=9 (≥N), d=8'hFF -> rsp_out=8'h00 after 4 cycles.
  - amt=8, d=8'h01 -> 8'h00.
- **Backpressure:** rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_out and rsp_id hold, and both readys stay 0. Raising rsp_ready -> IDLE on the next cycle, and a pending request is accepted one cycle later.
- **Reset mid-SHIFT:** req1 d=8'h01 amt=8; assert rst one cycle after accept -> no response ever appears, busy=0 and state IDLE on the next cycle, last=1 (req0 priority).

Source files
------------

// File: rtl/shift_scheduler.sv
// rtl/shift_scheduler.sv - two-requester round-robin multi-cycle left-shift engine
//
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   req0_valid/req0_ready/d/amt       requester 0 request channel
//   req1_valid/req1_ready/d/amt       requester 1 request channel
//   rsp_valid/rsp_ready/rsp_out/id    result channel tagged with owner id
//   busy                              high whenever a job is in flight
module shift_scheduler #(
  parameter int N    = 8,
  parameter int A    = $clog2(N) + 1,
  parameter int STEP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_d,
  input  logic [A-1:0] req0_amt,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_d,
  input  logic [A-1:0] req1_amt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_out,
  output logic         rsp_id,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [A-1:0] N_A    = A'(N);
  localparam logic [A-1:0] STEP_A = A'(STEP);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [A-1:0] rem_q, rem_d;
  logic         id_q, id_d;
  logic         last_q, last_d;

  logic         grant0, grant1;
  logic         accept;
  logic [N-1:0] sel_d;
  logic [A-1:0] sel_amt, sel_rem;
  logic [A-1:0] step_s, rem_after;

  // With both valid the requester not served last wins; grants are
  // mutually exclusive by construction.
  assign grant0 = req0_valid && (!req1_valid ||  last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = (state_q == S_IDLE) && grant0 && rst;
  assign req1_ready = (state_q == S_IDLE) && grant1 && rst;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_d   = grant1 ? req1_d   : req0_d;
  assign sel_amt = grant1 ? req1_amt : req0_amt;
  // Amounts of N or more clear the operand, so clamp to N.
  assign sel_rem = (sel_amt >= N_A) ? N_A : sel_amt;

  assign step_s    = (rem_q < STEP_A) ? rem_q : STEP_A;
  assign rem_after = rem_q - step_s;

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_out   = acc_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = sel_d;
          rem_d   = sel_rem;
          id_d    = grant1;
          // A zero amount skips straight to the response state.
          state_d = (sel_rem != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        acc_d = acc_q << step_s;
        rem_d = rem_after;
        if (rem_after == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_shift_scheduler.sv
// tb/tb_shift_scheduler.sv - self-checking bench for shift_scheduler
module tb_shift_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_d;
  logic [3:0] req0_amt;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_d;
  logic [3:0] req1_amt;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_out;
  logic       rsp_id;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [3:0] a0;
    logic [7:0] d1;
    logic [3:0] a1;
    logic       exp_id;
    logic [7:0] exp_out;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       id;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  shift_scheduler #(.N(8), .A(4), .STEP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_d     (req0_d),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_d     (req1_d),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: responses are compared at the handshake, against entries
  // pushed when the matching stimulus was driven.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_out", 32'(rsp_out), 32'(e.out));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  task automatic run_job(input vec_t v, input string tag);
    int cyc;
    req0_valid = v.v0; req0_d = v.d0; req0_amt = v.a0;
    req1_valid = v.v1; req1_d = v.d1; req1_amt = v.a1;
    #1;
    chk({tag, " ready0"}, 32'(req0_ready), 32'(v.exp_id == 1'b0));
    chk({tag, " ready1"}, 32'(req1_ready), 32'(v.exp_id == 1'b1));
    exp_q.push_back('{out: v.exp_out, id: v.exp_id});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(v.exp_lat));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " busy_after_rsp"}, 32'(busy), 32'd0);
    chk({tag, " rsp_valid_low"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   cyc;

    //            v0    v1    d0     a0     d1     a1     id    out    lat
    vecs[0] = '{1'b1, 1'b1, 8'h81, 4'd1, 8'h0F, 4'd4, 1'b0, 8'h02, 1};
    vecs[1] = '{1'b1, 1'b1, 8'h81, 4'd1, 8'h0F, 4'd4, 1'b1, 8'hF0, 2};
    vecs[2] = '{1'b1, 1'b1, 8'h81, 4'd1, 8'h0F, 4'd4, 1'b0, 8'h02, 1};
    vecs[3] = '{1'b1, 1'b0, 8'h01, 4'd3, 8'hEE, 4'd1, 1'b0, 8'h08, 2};
    vecs[4] = '{1'b0, 1'b1, 8'h33, 4'd2, 8'hA5, 4'd0, 1'b1, 8'hA5, 0};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 4'd9, 8'h00, 4'd0, 1'b0, 8'h00, 4};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 4'd0, 8'h01, 4'd8, 1'b1, 8'h00, 4};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 4'd0, 8'h3C, 4'd5, 1'b1, 8'h80, 3};
    vecs[8] = '{1'b1, 1'b0, 8'hB7, 4'd7, 8'h00, 4'd0, 1'b0, 8'h80, 4};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 4'd0, 8'h5A, 4'd2, 1'b1, 8'h68, 1};

    // Reset with both requesters pushing.
    rst = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_d = 8'h55; req0_amt = 4'd1;
    req1_valid = 1'b1; req1_d = 8'hAA; req1_amt = 4'd1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst ready0", 32'(req0_ready), 32'd0);
      chk("rst ready1", 32'(req1_ready), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_out", 32'(rsp_out), 32'd0);
      chk("rst rsp_id", 32'(rsp_id), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
    end
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold the response 5 cycles while req1 waits.
    req0_valid = 1'b1; req0_d = 8'h0F; req0_amt = 4'd2;
    #1;
    chk("bp ready0", 32'(req0_ready), 32'd1);
    exp_q.push_back('{out: 8'h3C, id: 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_d = 8'h11; req1_amt = 4'd0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp latency", 32'(cyc), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 32'(rsp_valid), 32'd1);
      chk("bp hold out", 32'(rsp_out), 32'h3C);
      chk("bp hold id", 32'(rsp_id), 32'd0);
      chk("bp ready0 low", 32'(req0_ready), 32'd0);
      chk("bp ready1 low", 32'(req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    exp_q.push_back('{out: 8'h11, id: 1'b1});
    @(posedge clk); #1;
    chk("bp idle busy", 32'(busy), 32'd0);
    chk("bp pending ready1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("bp second accept busy", 32'(busy), 32'd1);
    chk("bp second valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp back idle", 32'(busy), 32'd0);

    // Serve req0 so that last points at requester 0 before the abort.
    v = '{1'b1, 1'b0, 8'h03, 4'd1, 8'h00, 4'd0, 1'b0, 8'h06, 1};
    run_job(v, "pre_abort");

    // Reset one cycle into a long SHIFT job.
    req1_valid = 1'b1; req1_d = 8'h01; req1_amt = 4'd8;
    #1;
    chk("abort ready1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("abort busy_accept", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort no rsp", 32'(rsp_valid), 32'd0);
      chk("abort idle", 32'(busy), 32'd0);
    end
    v = '{1'b1, 1'b1, 8'h81, 4'd1, 8'h0F, 4'd4, 1'b0, 8'h02, 1};
    run_job(v, "post_abort");

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
